// File: rtl/arm_rf_pkg.sv
// arm_rf_pkg
// Shared types and helpers for the banked ARM register file.
//   mode_e   : processor mode as presented on mode_i (3 = reserved, behaves as USR)
//   REG_*    : architectural register numbers with special meaning
//   phys_idx : maps (mode, architectural register) to a physical storage slot
// Physical layout: slots 0-12 hold the common R0-R12, 13/14 hold USR SP/LR,
// 15/16 hold IRQ SP/LR, 17/18 hold SVC SP/LR.
package arm_rf_pkg;

   typedef enum logic [1:0] {
      MODE_USR = 2'd0,
      MODE_IRQ = 2'd1,
      MODE_SVC = 2'd2,
      MODE_RSV = 2'd3
   } mode_e;

   localparam logic [3:0] REG_SP = 4'd13;
   localparam logic [3:0] REG_LR = 4'd14;
   localparam logic [3:0] REG_PC = 4'd15;

   localparam int NUM_PHYS = 19;

   // R15 has no storage; callers must filter it out before using the index.
   function automatic logic [4:0] phys_idx(input logic [1:0] mode, input logic [3:0] r);
      logic [4:0] base;
      if (r < REG_SP) begin
         return {1'b0, r};
      end
      case (mode)
         MODE_IRQ: base = 5'd15;
         MODE_SVC: base = 5'd17;
         default:  base = 5'd13;
      endcase
      // r is 13 (SP) or 14 (LR); SP has bit0 set and takes the first slot of the bank.
      return base + {4'd0, ~r[0]};
   endfunction

endpackage

// File: rtl/arm_regfile_banked_if.sv
// arm_regfile_banked_if
// Writeback-side bus of the register file: two write ports plus the exported
// R15 write (branch request).
//   we_a/wa_a/wd_a : write port A (ALU / base writeback)
//   we_b/wa_b/wd_b : write port B (load data)
//   pc_wr_o/pc_wd_o: R15 write request and its data, driven by the register file
// Modports: master = writeback stage, slave = register file.
interface arm_regfile_banked_if #(
   parameter int DATA_W = 32
);
   logic              we_a;
   logic [3:0]        wa_a;
   logic [DATA_W-1:0] wd_a;
   logic              we_b;
   logic [3:0]        wa_b;
   logic [DATA_W-1:0] wd_b;
   logic              pc_wr_o;
   logic [DATA_W-1:0] pc_wd_o;

   modport master (
      output we_a, wa_a, wd_a, we_b, wa_b, wd_b,
      input  pc_wr_o, pc_wd_o
   );

   modport slave (
      input  we_a, wa_a, wd_a, we_b, wa_b, wd_b,
      output pc_wr_o, pc_wd_o
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Outstanding-load tracker: one busy bit per architectural register R0-R14,
// shared across mode banks, with NUM_RD combinational lookup ports.
//   clk, rst_n          : clock, asynchronous active-low reset
//   set_i, set_idx_i    : mark register busy at the next edge (load issued)
//   clr_i, clr_idx_i    : mark register free at the next edge (load returned)
//   ra_i                : lookup addresses, port k at [4k+3:4k]
//   busy_o              : busy bit per lookup port, 0 for R15
module rf_scoreboard #(
   parameter int NUM_RD = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_i,
   input  logic [3:0]        set_idx_i,
   input  logic              clr_i,
   input  logic [3:0]        clr_idx_i,
   input  logic [4*NUM_RD-1:0] ra_i,
   output logic [NUM_RD-1:0] busy_o
);

   logic [14:0] busy;
   logic [15:0] busy_ext;

   // A set and clear of the same register in one cycle means a new load was
   // issued as the old one returned, so the set takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < 15; i++) begin
            if (set_i && set_idx_i == 4'(i)) begin
               busy[i] <= 1'b1;
            end else if (clr_i && clr_idx_i == 4'(i)) begin
               busy[i] <= 1'b0;
            end
         end
      end
   end

   // Bit 15 is a constant zero so R15 lookups need no special case.
   assign busy_ext = {1'b0, busy};

   for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
      assign busy_o[k] = busy_ext[ra_i[4*k +: 4]];
   end

endmodule

// File: rtl/arm_regfile_banked.sv
// arm_regfile_banked
// 16-entry ARM register file with IRQ/SVC banking of R13/R14, NUM_RD
// combinational read ports, two write ports and a load scoreboard.
//   clk, rst_n  : clock, asynchronous active-low reset
//   mode_i      : processor mode selecting the R13/R14 bank (reads and writes)
//   ra_i/rd_o   : read addresses / data, port k in slice k; R15 reads return pc8_i
//   busy_o      : per read port, addressed register has an outstanding load
//   pc8_i       : PC+8 value returned for R15 reads
//   ld_issue_i, ld_dst_i : load issue marking ld_dst_i busy
//   wr          : write ports A/B and exported R15 write (arm_regfile_banked_if.slave)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports and mask busy for a register being written back by port B.
module arm_regfile_banked
   import arm_rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_RD = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               mode_i,
   input  logic [4*NUM_RD-1:0]      ra_i,
   output logic [DATA_W*NUM_RD-1:0] rd_o,
   output logic [NUM_RD-1:0]        busy_o,
   input  logic [DATA_W-1:0]        pc8_i,
   input  logic                     ld_issue_i,
   input  logic [3:0]               ld_dst_i,
   arm_regfile_banked_if.slave      wr
);

   logic [DATA_W-1:0] regs [NUM_PHYS];
   logic              a_wr, b_wr, a_pc, b_pc;
   logic [4:0]        pa, pb;
   logic [NUM_RD-1:0] sb_busy;

   assign a_pc = wr.we_a && (wr.wa_a == REG_PC);
   assign b_pc = wr.we_b && (wr.wa_b == REG_PC);
   assign b_wr = wr.we_b && !b_pc;
   // Port A loses to port B when both target the same register.
   assign a_wr = wr.we_a && !a_pc && !(b_wr && wr.wa_b == wr.wa_a);
   assign pa   = phys_idx(mode_i, wr.wa_a);
   assign pb   = phys_idx(mode_i, wr.wa_b);

   // R15 is never stored; a write to it becomes a branch request, port B first.
   assign wr.pc_wr_o = a_pc || b_pc;
   assign wr.pc_wd_o = b_pc ? wr.wd_b : wr.wd_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PHYS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (a_wr) begin
            regs[pa] <= wr.wd_a;
         end
         if (b_wr) begin
            regs[pb] <= wr.wd_b;
         end
      end
   end

   rf_scoreboard #(.NUM_RD(NUM_RD)) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_i     (ld_issue_i && (ld_dst_i != REG_PC)),
      .set_idx_i (ld_dst_i),
      .clr_i     (b_wr),
      .clr_idx_i (wr.wa_b),
      .ra_i      (ra_i),
      .busy_o    (sb_busy)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [3:0]        ra;
      logic [DATA_W-1:0] rdata;

      assign ra = ra_i[4*k +: 4];

      always_comb begin
         rdata = regs[phys_idx(mode_i, ra)];
         if (ra == REG_PC) begin
            rdata = pc8_i;
`ifdef REGFILE_BYPASS_EN
         end else if (b_wr && wr.wa_b == ra) begin
            rdata = wr.wd_b;
         end else if (wr.we_a && !a_pc && wr.wa_a == ra) begin
            rdata = wr.wd_a;
`endif
         end
      end

      assign rd_o[DATA_W*k +: DATA_W] = rdata;

`ifdef REGFILE_BYPASS_EN
      // The load returning this cycle resolves the hazard for a forwarded read.
      assign busy_o[k] = sb_busy[k] && !(b_wr && wr.wa_b == ra);
`else
      assign busy_o[k] = sb_busy[k];
`endif
   end

endmodule
